// File: rtl/dma_rd_req_arbiter_pkg.sv
// Shared types and helpers for the DMA read-request arbiter.
// Holds the FSM state encoding and the byte-length to completion-beat conversion.
package dma_rd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RELEASE  = 2'd2
  } arb_state_e;

  // A length field of zero means a full 4 KiB read.
  localparam logic [11:0] LEN_4K   = 12'd0;
  localparam logic [8:0]  BEATS_4K = 9'd256;

  // Number of 128-bit completion beats a read of 'len' bytes returns.
  function automatic logic [8:0] beats(input logic [11:0] len);
    logic [8:0] b;
    if (len == LEN_4K) begin
      b = BEATS_4K;
    end else begin
      b = {1'b0, len[11:4]} + {8'd0, |len[3:0]};
    end
    return b;
  endfunction

endpackage

// File: rtl/dma_rd_req_arbiter_if.sv
// PCIe-side bundle of the DMA read-request arbiter: the outgoing read-request
// channel and the incoming completion-beat notifications.
// Signal suffixes are named from the arbiter's point of view.
interface dma_rd_req_arbiter_if;

  logic        rd_req_o;
  logic [31:0] rd_req_addr_o;
  logic [11:0] rd_req_len_o;
  logic [7:0]  rd_req_tag_o;
  logic        rd_req_ack_i;
  logic        cpl_valid_i;
  logic [7:0]  cpl_tag_i;

  // Arbiter side
  modport master (
    output rd_req_o,
    output rd_req_addr_o,
    output rd_req_len_o,
    output rd_req_tag_o,
    input  rd_req_ack_i,
    input  cpl_valid_i,
    input  cpl_tag_i
  );

  // PCIe TX read-request engine side
  modport slave (
    input  rd_req_o,
    input  rd_req_addr_o,
    input  rd_req_len_o,
    input  rd_req_tag_o,
    output rd_req_ack_i,
    output cpl_valid_i,
    output cpl_tag_i
  );

endinterface

// File: rtl/dma_rd_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after the
// pointer, wrapping around. Produces a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_any_o
);

  logic found;

  // Scan positions ptr, ptr+1, ... (mod NUM_REQ) and take the first eligible one.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && eligible_i[k] && (k == ((int'(ptr_i) + off) % NUM_REQ))) begin
          found       = 1'b1;
          grant_o[k]  = 1'b1;
          grant_idx_o = IDX_W'(k);
        end
      end
    end
    grant_any_o = found;
  end

endmodule

// File: rtl/dma_rd_req_arbiter.sv
// Shares the single PCIe DMA read-request channel between NUM_REQ requesters.
// Round-robin grant, tag = requester index, and a per-requester outstanding
// completion-beat credit so no requester over-subscribes its receive FIFO.
module dma_rd_req_arbiter
  import dma_rd_arb_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int MAX_OUT_BEATS = 512,
  parameter int CNT_W         = 16
) (
  input  logic                  i_pcie_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*32-1:0] req_addr_i,
  input  logic [NUM_REQ*12-1:0] req_len_i,
  output logic [NUM_REQ-1:0]    req_ack_o,
  dma_rd_req_arbiter_if.master  pcie,
  output logic [NUM_REQ-1:0]    busy_o,
  output logic                  err_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic               rd_req_q, rd_req_d;
  logic [31:0]        addr_q, addr_d;
  logic [11:0]        len_q, len_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0] busy_q, busy_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   out_cnt_q [NUM_REQ];
  logic [CNT_W-1:0]   out_cnt_d [NUM_REQ];

  logic [CNT_W-1:0]   req_beats [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant_oh;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               grant_fire;

  // A requester may be granted only if its whole read still fits its receive FIFO.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_beats[k] = CNT_W'(beats(req_len_i[12*k +: 12]));
      eligible[k]  = req_i[k] &&
                     ((out_cnt_q[k] + req_beats[k]) <= CNT_W'(MAX_OUT_BEATS));
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .eligible_i  (eligible),
    .ptr_i       (ptr_q),
    .grant_o     (grant_oh),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  // Request FSM: grant in IDLE, hold the request until the engine accepts it, then one quiet cycle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    rd_req_d   = rd_req_q;
    addr_d     = addr_q;
    len_d      = len_q;
    req_ack_d  = '0;
    grant_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          grant_fire = 1'b1;
          gnt_d      = grant_idx;
          rd_req_d   = 1'b1;
          for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_oh[k]) begin
              addr_d = req_addr_i[32*k +: 32];
              len_d  = req_len_i[12*k +: 12];
            end
          end
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (pcie.rd_req_ack_i) begin
          rd_req_d  = 1'b0;
          req_ack_d = NUM_REQ'(1) << gnt_q;
          ptr_d     = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Credit counters: charge at grant, return one beat per completion; a completion
  // landing in the same cycle as a charge on the same requester is netted against it.
  always_comb begin
    err_d = err_q;
    if (pcie.cpl_valid_i && (pcie.cpl_tag_i >= 8'(NUM_REQ))) begin
      err_d = 1'b1;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      out_cnt_d[k] = out_cnt_q[k];
      if (grant_fire && grant_oh[k] && pcie.cpl_valid_i && (pcie.cpl_tag_i == 8'(k))) begin
        out_cnt_d[k] = out_cnt_q[k] + req_beats[k] - CNT_W'(1);
      end else if (grant_fire && grant_oh[k]) begin
        out_cnt_d[k] = out_cnt_q[k] + req_beats[k];
      end else if (pcie.cpl_valid_i && (pcie.cpl_tag_i == 8'(k))) begin
        if (out_cnt_q[k] == '0) begin
          err_d = 1'b1;
        end else begin
          out_cnt_d[k] = out_cnt_q[k] - CNT_W'(1);
        end
      end
      busy_d[k] = (out_cnt_d[k] != '0);
    end
  end

  // State, request register, credit counters and flags; reset clears everything at once.
  always_ff @(posedge i_pcie_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      rd_req_q  <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      req_ack_q <= '0;
      busy_q    <= '0;
      err_q     <= 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
        out_cnt_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      rd_req_q  <= rd_req_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      req_ack_q <= req_ack_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      for (int k = 0; k < NUM_REQ; k++) begin
        out_cnt_q[k] <= out_cnt_d[k];
      end
    end
  end

  assign pcie.rd_req_o      = rd_req_q;
  assign pcie.rd_req_addr_o = addr_q;
  assign pcie.rd_req_len_o  = len_q;
  assign pcie.rd_req_tag_o  = 8'(gnt_q);
  assign req_ack_o          = req_ack_q;
  assign busy_o             = busy_q;
  assign err_o              = err_q;

endmodule

// File: tb/tb_dma_rd_req_arbiter.sv
// Directed testbench for dma_rd_req_arbiter (NUM_REQ=2, MAX_OUT_BEATS=512).
// Expected values are hand-computed from the beat/credit rules.
module tb_dma_rd_req_arbiter;

  localparam int NUM_REQ = 2;

  logic                  i_pcie_clk;
  logic                  i_rst_n;
  logic [NUM_REQ-1:0]    req_i;
  logic [NUM_REQ*32-1:0] req_addr_i;
  logic [NUM_REQ*12-1:0] req_len_i;
  logic [NUM_REQ-1:0]    req_ack_o;
  logic [NUM_REQ-1:0]    busy_o;
  logic                  err_o;

  int check_cnt = 0;
  int error_cnt = 0;

  dma_rd_req_arbiter_if pcie_if ();

  dma_rd_req_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .MAX_OUT_BEATS (512),
    .CNT_W         (16)
  ) dut (
    .i_pcie_clk (i_pcie_clk),
    .i_rst_n    (i_rst_n),
    .req_i      (req_i),
    .req_addr_i (req_addr_i),
    .req_len_i  (req_len_i),
    .req_ack_o  (req_ack_o),
    .pcie       (pcie_if),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  initial i_pcie_clk = 1'b0;
  always #5 i_pcie_clk = ~i_pcie_clk;

  task automatic tick();
    @(posedge i_pcie_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_cnt++;
    if (observed !== expected) begin
      error_cnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyReset();
    i_rst_n              = 1'b0;
    req_i                = '0;
    req_addr_i           = '0;
    req_len_i            = '0;
    pcie_if.rd_req_ack_i = 1'b0;
    pcie_if.cpl_valid_i  = 1'b0;
    pcie_if.cpl_tag_i    = '0;
    repeat (3) tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic sendCompletions(input logic [7:0] tag, input int n);
    pcie_if.cpl_valid_i = 1'b1;
    pcie_if.cpl_tag_i   = tag;
    for (int i = 0; i < n; i++) tick();
    pcie_if.cpl_valid_i = 1'b0;
  endtask

  // Raise req k, wait for the forwarded request (or confirm it never comes), ack it, drop req.
  task automatic applyStimulus(input string name, input int k, input logic [31:0] addr,
                               input logic [11:0] len, input bit cpl_same, input bit expect_grant);
    int seen_cyc;
    int limit;
    seen_cyc = -1;
    limit    = expect_grant ? 20 : 10;
    req_i[k]              = 1'b1;
    req_addr_i[32*k +: 32] = addr;
    req_len_i[12*k +: 12]  = len;
    if (cpl_same) begin
      pcie_if.cpl_valid_i = 1'b1;
      pcie_if.cpl_tag_i   = 8'(k);
    end
    for (int c = 0; c < limit; c++) begin
      tick();
      pcie_if.cpl_valid_i = 1'b0;
      if (pcie_if.rd_req_o) begin
        seen_cyc = c;
        break;
      end
    end
    checkOutput({name, "_granted"}, 32'(seen_cyc >= 0), 32'(expect_grant));
    if (seen_cyc >= 0) begin
      checkOutput({name, "_latency"}, 32'(seen_cyc), 32'd0);
      checkOutput({name, "_tag"}, 32'(pcie_if.rd_req_tag_o), 32'(k));
      checkOutput({name, "_addr"}, pcie_if.rd_req_addr_o, addr);
      checkOutput({name, "_len"}, 32'(pcie_if.rd_req_len_o), 32'(len));
      tick();
      checkOutput({name, "_hold"}, 32'(pcie_if.rd_req_o), 32'd1);
      checkOutput({name, "_hold_addr"}, pcie_if.rd_req_addr_o, addr);
      checkOutput({name, "_noack_yet"}, 32'(req_ack_o), 32'd0);
      pcie_if.rd_req_ack_i = 1'b1;
      tick();
      pcie_if.rd_req_ack_i = 1'b0;
      checkOutput({name, "_ack"}, 32'(req_ack_o), 32'd1 << k);
      checkOutput({name, "_rdreq_drop"}, 32'(pcie_if.rd_req_o), 32'd0);
      req_i[k] = 1'b0;
      tick();
      checkOutput({name, "_ack_pulse"}, 32'(req_ack_o), 32'd0);
    end else begin
      req_i[k] = 1'b0;
      tick();
    end
  endtask

  initial begin
    int n;
    int exp_tag [4];
    exp_tag = '{0, 1, 0, 1};

    // Test 1: reset state, single 4 KiB request, exact 256-beat charge
    i_rst_n = 1'b0;
    #2;
    checkOutput("rst_rdreq", 32'(pcie_if.rd_req_o), 32'd0);
    applyReset();
    checkOutput("rst_rdreq_after", 32'(pcie_if.rd_req_o), 32'd0);
    checkOutput("rst_ack", 32'(req_ack_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_err", 32'(err_o), 32'd0);
    applyStimulus("t1", 0, 32'h0000_1000, 12'd0, 1'b0, 1'b1);
    checkOutput("t1_busy", 32'(busy_o), 32'd1);
    sendCompletions(8'd0, 255);
    checkOutput("t1_busy_255", 32'(busy_o), 32'd1);
    sendCompletions(8'd0, 1);
    checkOutput("t1_busy_256", 32'(busy_o), 32'd0);
    checkOutput("t1_err", 32'(err_o), 32'd0);

    // Test 2: both requesters held high, engine acks immediately -> 0,1,0,1
    applyReset();
    req_addr_i           = {32'hB000_0000, 32'hA000_0000};
    req_len_i            = {12'd16, 12'd16};
    req_i                = 2'b11;
    pcie_if.rd_req_ack_i = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      if (pcie_if.rd_req_o) begin
        checkOutput($sformatf("t2_tag%0d", n), 32'(pcie_if.rd_req_tag_o), 32'(exp_tag[n]));
        checkOutput($sformatf("t2_addr%0d", n), pcie_if.rd_req_addr_o,
                    (exp_tag[n] == 0) ? 32'hA000_0000 : 32'hB000_0000);
        tick();
        checkOutput($sformatf("t2_ack%0d", n), 32'(req_ack_o), 32'd1 << exp_tag[n]);
        n++;
      end
    end
    req_i                = 2'b00;
    pcie_if.rd_req_ack_i = 1'b0;
    checkOutput("t2_grants", 32'(n), 32'd4);
    tick();
    checkOutput("t2_busy", 32'(busy_o), 32'd3);
    sendCompletions(8'd0, 2);
    sendCompletions(8'd1, 2);
    checkOutput("t2_drained", 32'(busy_o), 32'd0);

    // Test 3: credit exhaustion on req1 skips it without blocking req0
    applyStimulus("t3_r1a", 1, 32'h0000_2000, 12'd0, 1'b0, 1'b1);
    applyStimulus("t3_r1b", 1, 32'h0000_3000, 12'd0, 1'b0, 1'b1);
    checkOutput("t3_busy", 32'(busy_o), 32'd2);
    applyStimulus("t3_r1full", 1, 32'h0000_4000, 12'd0, 1'b0, 1'b0);
    req_i[1] = 1'b1;
    applyStimulus("t3_r0", 0, 32'h0000_5000, 12'd16, 1'b0, 1'b1);
    req_i[1] = 1'b0;
    sendCompletions(8'd1, 255);
    applyStimulus("t3_r1_257", 1, 32'h0000_4000, 12'd0, 1'b0, 1'b0);
    sendCompletions(8'd1, 1);
    applyStimulus("t3_r1again", 1, 32'h0000_6000, 12'd0, 1'b0, 1'b1);
    checkOutput("t3_busy_end", 32'(busy_o), 32'd3);

    // Test 4: len 17 charges 2 beats; same-cycle completion nets to +1
    applyReset();
    applyStimulus("t4_pre", 0, 32'h0000_7000, 12'd16, 1'b0, 1'b1);
    applyStimulus("t4_len17", 0, 32'h0000_7100, 12'd17, 1'b1, 1'b1);
    sendCompletions(8'd0, 1);
    checkOutput("t4_busy_1left", 32'(busy_o), 32'd1);
    sendCompletions(8'd0, 1);
    checkOutput("t4_busy_empty", 32'(busy_o), 32'd0);
    checkOutput("t4_err", 32'(err_o), 32'd0);

    // Test 5: completion on an empty counter, and with an out-of-range tag
    applyReset();
    sendCompletions(8'd0, 1);
    checkOutput("t5_err_zero", 32'(err_o), 32'd1);
    checkOutput("t5_no_underflow", 32'(busy_o), 32'd0);
    applyReset();
    checkOutput("t5_err_cleared", 32'(err_o), 32'd0);
    applyStimulus("t5_r1", 1, 32'h0000_8000, 12'd16, 1'b0, 1'b1);
    sendCompletions(8'd5, 1);
    checkOutput("t5_err_tag", 32'(err_o), 32'd1);
    checkOutput("t5_busy_kept", 32'(busy_o), 32'd2);
    repeat (3) tick();
    sendCompletions(8'd1, 1);
    checkOutput("t5_busy_drained", 32'(busy_o), 32'd0);
    checkOutput("t5_err_sticky", 32'(err_o), 32'd1);

    // Test 6: reset during WAIT_ACK clears outputs without waiting for a clock
    applyReset();
    req_addr_i[31:0] = 32'h0000_9000;
    req_len_i[11:0]  = 12'd0;
    req_i[0]         = 1'b1;
    tick();
    checkOutput("t6_waitack", 32'(pcie_if.rd_req_o), 32'd1);
    checkOutput("t6_busy_pre", 32'(busy_o), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("t6_async_rdreq", 32'(pcie_if.rd_req_o), 32'd0);
    checkOutput("t6_async_ack", 32'(req_ack_o), 32'd0);
    checkOutput("t6_async_busy", 32'(busy_o), 32'd0);
    req_i[0] = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();
    applyStimulus("t6_resume", 1, 32'h0000_A000, 12'd16, 1'b0, 1'b1);
    sendCompletions(8'd0, 1);
    checkOutput("t6_stale_cpl", 32'(err_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule
